// File: rtl/series_sum_engine.sv
// series_sum_engine: iterative series accumulator.
// On an accepted start it sums t(k) for k = n down to 1, one term per clock,
// where t(k) is k, k*k or 2k-1 depending on the latched mode. It then presents
// the result on sum/ovf together with a single-cycle done pulse.
module series_sum_engine #(
    parameter int N_W   = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] sum,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_LIN = 2'b00,  // sum of k
        M_SQR = 2'b01,  // sum of k*k
        M_ODD = 2'b10,  // sum of 2k-1
        M_RSV = 2'b11   // reserved, behaves as M_LIN
    } mode_t;

    // Working width for the term and the add. It holds the full 2*N_W-bit
    // square and the full accumulator, plus one spare bit so that an oversized
    // term or a carry out of OUT_W always shows up above bit OUT_W-1.
    localparam int T_W = ((2 * N_W > OUT_W) ? 2 * N_W : OUT_W) + 1;

    state_t           state;
    mode_t            mode_q;
    logic [N_W-1:0]   k;
    logic [OUT_W-1:0] acc;
    logic             acc_ovf;

    logic [T_W-1:0]   k_ext;
    logic [T_W-1:0]   term;
    logic [T_W:0]     sum_wide;
    logic [OUT_W-1:0] acc_next;
    logic             ovf_next;

    // Term generation and accumulate: the post-add values that RUN commits
    // and that are forwarded to sum/ovf on the final term.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        term  = '0;
        k_ext = T_W'(k);
        unique case (mode_q)
            M_SQR:   term = k_ext * k_ext;
            M_ODD:   term = (k_ext << 1) - T_W'(1);
            default: term = k_ext;
        endcase
        sum_wide = {1'b0, T_W'(acc)} + {1'b0, term};
        acc_next = sum_wide[OUT_W-1:0];
        // Any bit at or above OUT_W means either the term alone did not fit
        // or the add carried out. acc is always below 2^OUT_W.
        ovf_next = acc_ovf | (|sum_wide[T_W:OUT_W]);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mode_q  <= M_LIN;
            k       <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            ovf     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // right-hand side then sees the pre-edge value, whatever the
            // statement order.
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode_t'(mode);
                        k       <= n;
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                        busy    <= 1'b1;
                        if (n == '0) begin
                            // Empty series: the result is zero and is
                            // published immediately.
                            state <= S_DONE;
                            done  <= 1'b1;
                            sum   <= '0;
                            ovf   <= 1'b0;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc     <= acc_next;
                    acc_ovf <= ovf_next;
                    k       <= k - N_W'(1);
                    if (k == N_W'(1)) begin
                        // Last term: publish the post-add values on the
                        // same edge.
                        state <= S_DONE;
                        done  <= 1'b1;
                        sum   <= acc_next;
                        ovf   <= ovf_next;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_series_sum_engine.sv
// tb_series_sum_engine: directed bench for series_sum_engine.
// The reference model predicts each result with plain integer arithmetic
// from n and mode. It predicts the handshake timing as a countdown of n edges
// from the accepted start. A compare process checks all outputs against this
// model on every falling edge. Each run also checks hand-computed literals.
module tb_series_sum_engine;

    localparam int N_W   = 8;
    localparam int OUT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [N_W-1:0]   n;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] sum;
    logic             ovf;

    int vectors = 0;
    int errors  = 0;
    bit cmp_en  = 1'b0;

    series_sum_engine #(.N_W(N_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .n     (n),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The true series sum, computed with wide integers. The reported sum is
    // this value mod 2^OUT_W. The partial sums only grow, so overflow means
    // that the final true sum exceeds 2^OUT_W-1.
    function automatic longint true_sum(input int nn, input int md);
        longint s = 0;
        for (int kk = 1; kk <= nn; kk++) begin
            case (md)
                1:       s += longint'(kk) * kk;
                2:       s += 2 * kk - 1;
                default: s += kk;
            endcase
        end
        return s;
    endfunction

    // Reference model: busy/done timing as a countdown, results from true_sum.
    logic             m_busy, m_done, m_ovf, p_ovf;
    logic [OUT_W-1:0] m_sum, p_sum;
    int               m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_ovf  <= 1'b0;
            p_sum  <= '0;
            p_ovf  <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_sum  <= p_sum;
                m_ovf  <= p_ovf;
            end
        end else if (start) begin
            longint ts;
            ts = true_sum(int'(n), int'(mode));
            m_busy <= 1'b1;
            if (n == 0) begin
                m_done <= 1'b1;
                m_sum  <= '0;
                m_ovf  <= 1'b0;
            end else begin
                m_left <= int'(n);
                p_sum  <= OUT_W'(ts);
                p_ovf  <= (ts > longint'((1 << OUT_W) - 1));
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_sum",  sum,  m_sum);
            check("cyc_ovf",  ovf,  m_ovf);
        end
    end

    // Present a one-cycle start. Returns at the falling edge after E0.
    task automatic launch(input int nn, input int md);
        @(negedge clk);
        start = 1'b1;
        n     = N_W'(nn);
        mode  = 2'(md);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for completion from the current falling edge. Checks the done
    // latency (in cycles from now), the busy duration and the literal results.
    task automatic wait_done(input string name, input int exp_lat, input int exp_busy,
                             input int exp_sum, input int exp_ovf);
        int lat = -1;
        int bc  = 0;
        for (int i = 0; i <= exp_lat + 4; i++) begin
            if (i > 0) @(negedge clk);
            if (!busy) break;
            bc++;
            if (done) begin
                lat = i;
                check({name, "_sum"}, sum, exp_sum);
                check({name, "_ovf"}, ovf, exp_ovf);
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, bc, exp_busy);
    endtask

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        mode  = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum",  sum,  0);
        check("reset_ovf",  ovf,  0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Sanity-pin the model with hand-computed sums.
        check("model_sq10",  32'(true_sum(10, 1)), 385);
        check("model_sq255", 32'(true_sum(255, 1)), 5559680);

        launch(4, 0);   wait_done("lin4",    4, 5, 10, 0);
        launch(10, 1);  wait_done("sqr10",  10, 11, 385, 0);
        launch(10, 2);  wait_done("odd10",  10, 11, 100, 0);
        launch(5, 3);   wait_done("rsv5",    5, 6, 15, 0);
        launch(0, 1);   wait_done("zero",    0, 1, 0, 0);
        launch(255, 0); wait_done("lin255", 255, 256, 32640, 0);
        launch(255, 1); wait_done("sqr255", 255, 256, 54656, 1);
        launch(1, 2);   wait_done("odd1",    1, 2, 1, 0);

        // A start pulse during RUN must be ignored.
        launch(8, 0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        n     = N_W'(3);
        mode  = 2'b01;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 5, 6, 36, 0);

        // Back-to-back: accept a start on the first idle cycle.
        launch(3, 0);   wait_done("b2b_a",   3, 4, 6, 0);
        start = 1'b1;
        n     = N_W'(2);
        mode  = 2'b01;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_b",   2, 3, 5, 0);

        // Asynchronous reset in the middle of a long run.
        launch(200, 0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum",  sum,  0);
        check("abort_ovf",  ovf,  0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", seen_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
